// File: rtl/matvec_out_requant.sv
// Requantizes the 28-bit signed matvec8 y stream to a 14-bit stream with a per-vector last flag.
// Optional feature macro: SAT_COUNT_EN adds a sticky 16-bit saturated-element counter.
module matvec_out_requant #(
  parameter int K     = 8,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_valid,
  output logic        input_ready,
  input  logic [27:0] input_data,
  input  logic [4:0]  shift,
  output logic        output_valid,
  input  logic        output_ready,
  output logic [13:0] output_data,
  output logic        output_last,
  output logic [15:0] sat_count
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [13:0]        r_mem_data [DEPTH];
  logic               r_mem_last [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [NW-1:0]      r_count;
  logic               r_in_ready;
  logic [CW-1:0]      r_elem_cnt;
  logic [4:0]         r_shift_q;

  logic               w_push;
  logic               w_pop;
  logic               w_last;
  logic [NW-1:0]      w_count_next;
  logic [4:0]         w_shift_sel;
  logic [4:0]         w_s;
  logic signed [28:0] w_in_ext;
  logic signed [28:0] w_round;
  logic signed [28:0] w_t;
  logic [13:0]        w_q;

  assign w_push       = input_valid & r_in_ready;
  assign w_pop        = (r_count != '0) & output_ready;
  assign w_last       = (r_elem_cnt == CW'(K - 1));
  assign input_ready  = r_in_ready;
  assign output_valid = (r_count != '0);
  assign output_data  = r_mem_data[r_rd_ptr];
  assign output_last  = r_mem_last[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + NW'(1);
      2'b01:   w_count_next = r_count - NW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // The first element of a vector uses the live shift input; later elements use the latched copy.
  always_comb begin
    w_shift_sel = (r_elem_cnt == '0) ? shift : r_shift_q;
    w_s         = (w_shift_sel > 5'd27) ? 5'd27 : w_shift_sel;
    w_in_ext    = {input_data[27], input_data};
    w_round     = (w_s == 5'd0) ? 29'sd0 : (29'sd1 <<< (w_s - 5'd1));
    w_t         = (w_in_ext + w_round) >>> w_s;
    if (w_t > 29'sd8191) begin
      w_q = 14'h1FFF;
    end else if (w_t < -29'sd8192) begin
      w_q = 14'h2000;
    end else begin
      w_q = w_t[13:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_last[i] <= 1'b0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_q;
        r_mem_last[r_wr_ptr] <= w_last;
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < NW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_elem_cnt <= '0;
      r_shift_q  <= '0;
    end else if (w_push) begin
      if (r_elem_cnt == '0) begin
        r_shift_q <= shift;
      end
      r_elem_cnt <= w_last ? '0 : r_elem_cnt + CW'(1);
    end
  end

`ifdef SAT_COUNT_EN
  logic        w_sat;
  logic [15:0] r_sat_count;

  assign w_sat     = (w_t > 29'sd8191) || (w_t < -29'sd8192);
  assign sat_count = r_sat_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_count <= '0;
    end else if (w_push && w_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_matvec_out_requant.sv
// Self-checking bench for matvec_out_requant: directed scenarios plus a randomized run
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_matvec_out_requant;

  localparam int K     = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        input_valid;
  logic        input_ready;
  logic [27:0] input_data;
  logic [4:0]  shift;
  logic        output_valid;
  logic        output_ready;
  logic [13:0] output_data;
  logic        output_last;
  logic [15:0] sat_count;

  int errors;
  int checks;

  logic [14:0] expQ[$];
  logic [14:0] gotQ[$];
  int          mElem;
  int          mShift;
  int          mSat;

  matvec_out_requant #(.K(K), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .shift        (shift),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last),
    .sat_count    (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: round-half-up shift then clamp to the signed 14-bit range.
  function automatic logic [13:0] refRequant(input longint v, input int sh, output bit sat);
    int     s;
    longint t;
    s = (sh > 27) ? 27 : sh;
    t = (s > 0) ? ((v + (longint'(1) << (s - 1))) >>> s) : v;
    sat = 1'b0;
    if (t > 8191) begin
      t = 8191;
      sat = 1'b1;
    end else if (t < -8192) begin
      t = -8192;
      sat = 1'b1;
    end
    return t[13:0];
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset        = 1'b0;
    input_valid  = 1'b0;
    input_data   = '0;
    shift        = '0;
    output_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    expQ.delete();
    gotQ.delete();
    mElem  = 0;
    mShift = 0;
    mSat   = 0;
  endtask

  // One clock: drive at negedge, record what gets accepted/popped, then cross the rising edge.
  task automatic drive_cycle(input logic iv, input logic [27:0] din, input logic [4:0] sh,
                             input logic ordy);
    bit          acc;
    bit          sat;
    int          eff;
    logic [13:0] q;
    @(negedge clk);
    input_valid  = iv;
    input_data   = iv ? din : 28'($urandom);
    shift        = sh;
    output_ready = ordy;
    #1;
    acc = iv && input_ready;
    if (output_valid && ordy) gotQ.push_back({output_last, output_data});
    if (acc) begin
      eff = (mElem == 0) ? int'(sh) : mShift;
      if (mElem == 0) mShift = int'(sh);
      q = refRequant(longint'($signed(din)), eff, sat);
      expQ.push_back({(mElem == K - 1), q});
      mElem = (mElem + 1) % K;
      if (sat && mSat < 65535) mSat++;
    end
    @(posedge clk);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) drive_cycle(1'b0, 28'd0, 5'd0, 1'b1);
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    checks++;
    if (output_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", output_valid);
    end
    checks++;
    if (output_data !== 14'd0 || output_last !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_data: got %h/%b expected 0/0", output_data, output_last);
    end
    checks++;
    if (input_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 1", input_ready);
    end
    checks++;
    if (sat_count !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_sat: got %0d expected 0", sat_count);
    end
  endtask

  task automatic test_saturation();
    logic [13:0] want [3];
    logic [15:0] wantSat;
    want[0] = 14'd100; want[1] = 14'h1FFF; want[2] = 14'h2000;
    applyReset();
    drive_cycle(1'b1, 28'd100, 5'd0, 1'b1);
    drive_cycle(1'b1, 28'd9000, 5'd0, 1'b1);
    drive_cycle(1'b1, -28'sd9000, 5'd0, 1'b1);
    drain(4);
    checks++;
    if (gotQ.size() != 3) begin
      errors++; $display("[TB] FAIL sat_count_out: got %0d expected 3", gotQ.size());
    end
    for (int i = 0; i < 3 && i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[i][13:0] !== want[i]) begin
        errors++; $display("[TB] FAIL sat_data%0d: got %h expected %h", i, gotQ[i][13:0], want[i]);
      end
    end
`ifdef SAT_COUNT_EN
    wantSat = 16'd2;
`else
    wantSat = 16'd0;
`endif
    checks++;
    if (sat_count !== wantSat) begin
      errors++; $display("[TB] FAIL sat_counter: got %0d expected %0d", sat_count, wantSat);
    end
  endtask

  task automatic test_rounding();
    logic [27:0] ins  [4];
    logic [13:0] want [4];
    ins[0] = 28'd24; ins[1] = -28'sd24; ins[2] = 28'd23; ins[3] = -28'sd25;
    want[0] = 14'd2; want[1] = 14'h3FFF; want[2] = 14'd1; want[3] = 14'h3FFE;
    applyReset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, ins[i], (i == 0) ? 5'd4 : 5'd0, 1'b1);
    drain(4);
    checks++;
    if (gotQ.size() != 4) begin
      errors++; $display("[TB] FAIL round_count: got %0d expected 4", gotQ.size());
    end
    for (int i = 0; i < 4 && i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[i][13:0] !== want[i]) begin
        errors++; $display("[TB] FAIL round%0d: got %h expected %h", i, gotQ[i][13:0], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyReset();
    drive_cycle(1'b1, 28'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (output_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL latency: got valid %b expected 1", output_valid);
    end
    for (int i = 1; i < 16; i++) drive_cycle(1'b1, 28'(i), 5'd0, 1'b1);
    drive_cycle(1'b0, 28'd0, 5'd0, 1'b1);
    checks++;
    if (gotQ.size() != 16) begin
      errors++; $display("[TB] FAIL b2b_throughput: got %0d expected 16", gotQ.size());
    end
    for (int i = 0; i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[i] !== {(i == 7 || i == 15), 14'(i)}) begin
        errors++; $display("[TB] FAIL b2b_out%0d: got last=%b data=%0d expected last=%b data=%0d",
                           i, gotQ[i][14], gotQ[i][13:0], (i == 7 || i == 15), i);
      end
    end
  endtask

  task automatic test_backpressure();
    applyReset();
    for (int i = 1; i <= 6; i++) drive_cycle(1'b1, 28'(i * 10), 5'd0, 1'b0);
    #1;
    checks++;
    if (expQ.size() != 4 || input_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL full_stall: got accepted=%0d ready=%b expected 4/0",
                         expQ.size(), input_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 28'($urandom), 5'($urandom), 1'b0);
      #1;
      checks++;
      if (output_valid !== 1'b1 || output_data !== 14'd10) begin
        errors++; $display("[TB] FAIL head_hold%0d: got valid=%b data=%0d expected 1/10",
                           i, output_valid, output_data);
      end
    end
    drive_cycle(1'b0, 28'd0, 5'd0, 1'b1);
    #2;
    checks++;
    if (input_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_after_pop: got %b expected 1", input_ready);
    end
    drain(6);
    checks++;
    if (gotQ.size() != 4) begin
      errors++; $display("[TB] FAIL bp_count: got %0d expected 4", gotQ.size());
    end
    for (int i = 0; i < 4 && i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[i][13:0] !== 14'((i + 1) * 10)) begin
        errors++; $display("[TB] FAIL bp_order%0d: got %0d expected %0d", i, gotQ[i][13:0], (i + 1) * 10);
      end
    end
  endtask

  task automatic test_shift_latch();
    applyReset();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 28'd32, (i < 3) ? 5'd0 : 5'd4, 1'b1);
    drive_cycle(1'b1, 28'd32, 5'd4, 1'b1);
    drain(3);
    checks++;
    if (gotQ.size() != 9) begin
      errors++; $display("[TB] FAIL latch_count: got %0d expected 9", gotQ.size());
    end
    for (int i = 0; i < 9 && i < gotQ.size(); i++) begin
      checks++;
      if (gotQ[i][13:0] !== ((i < 8) ? 14'd32 : 14'd2)) begin
        errors++; $display("[TB] FAIL latch%0d: got %0d expected %0d", i, gotQ[i][13:0],
                           (i < 8) ? 32 : 2);
      end
    end
  endtask

  task automatic test_random();
    logic [27:0] d;
    logic [15:0] wantSat;
    applyReset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 1) == 0) d = 28'(int'($urandom_range(0, 40000)) - 20000);
      else d = 28'($urandom);
      drive_cycle($urandom_range(0, 3) != 0, d, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3) != 0);
    end
    drain(8);
    checks++;
    if (gotQ.size() != expQ.size()) begin
      errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", gotQ.size(), expQ.size());
    end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (gotQ[i] !== expQ[i]) begin
        errors++; $display("[TB] FAIL rand%0d: got last=%b data=%h expected last=%b data=%h",
                           i, gotQ[i][14], gotQ[i][13:0], expQ[i][14], expQ[i][13:0]);
      end
    end
`ifdef SAT_COUNT_EN
    wantSat = 16'(mSat);
`else
    wantSat = 16'd0;
`endif
    checks++;
    if (sat_count !== wantSat) begin
      errors++; $display("[TB] FAIL rand_sat: got %0d expected %0d", sat_count, wantSat);
    end
  endtask

  task automatic test_reset_midstream();
    applyReset();
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 28'(i), 5'd0, 1'b1);
    drive_cycle(1'b0, 28'd0, 5'd0, 1'b1);
    for (int i = 5; i <= 7; i++) drive_cycle(1'b1, 28'(i), 5'd0, 1'b0);
    @(negedge clk);
    input_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (output_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", output_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    expQ.delete();
    gotQ.delete();
    mElem = 0; mShift = 0; mSat = 0;
    #1;
    checks++;
    if (input_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", input_ready);
    end
    drive_cycle(1'b1, 28'd55, 5'd0, 1'b1);
    drain(2);
    checks++;
    if (gotQ.size() != 1 || gotQ[0] !== {1'b0, 14'd55}) begin
      errors++; $display("[TB] FAIL midreset_first: got n=%0d val=%h expected n=1 val=%h",
                         gotQ.size(), (gotQ.size() > 0) ? gotQ[0] : 15'h0, {1'b0, 14'd55});
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b0;
    input_valid  = 1'b0;
    input_data   = '0;
    shift        = '0;
    output_ready = 1'b0;
    test_reset();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_shift_latch();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
